// File: rtl/mpx_stereo_decoder_192_if.sv
// Sample-stream interface of the 192 kHz MPX stereo decoder.
// Inputs: clken_192 sample strobe and the signed 20-bit composite sample MPX_IN.
// Outputs: signed 18-bit LO_LEFT/LO_RIGHT, ready_block_48 pulse, sticky overrun, pilot_locked.
interface mpx_stereo_decoder_192_if;
  logic               clken_192;
  logic signed [19:0] MPX_IN;
  logic signed [17:0] LO_LEFT;
  logic signed [17:0] LO_RIGHT;
  logic               ready_block_48;
  logic               overrun;
  logic               pilot_locked;

  // master drives the sample stream, slave is the decoder
  modport master (
    output clken_192, MPX_IN,
    input  LO_LEFT, LO_RIGHT, ready_block_48, overrun, pilot_locked
  );
  modport slave (
    input  clken_192, MPX_IN,
    output LO_LEFT, LO_RIGHT, ready_block_48, overrun, pilot_locked
  );
endinterface

// File: rtl/mpx_stereo_decoder_192.sv
// FM stereo MPX decoder: coherent 38 kHz side demodulation, 4:1 accumulate-and-dump to 48 kHz, saturated L/R.
// Latency: ready_block_48 is high 11 cycles after the clken_192 of the last sample of a block (20 with pilot detect).
// Backpressure: none; a clken_192 arriving while busy is dropped and sets the sticky overrun flag.
// Ports: clock, reset (synchronous, active high), bus (slave modport: clken_192, MPX_IN in; LO_LEFT, LO_RIGHT,
//        ready_block_48, overrun, pilot_locked out).
// Optional: define PILOT_DETECT_EN for the 19 kHz pilot correlator and mono fallback; otherwise pilot_locked is 0.
// The sine tables are built from a 17-entry quarter wave (round(127*sin)), matching the 64-entry DDS LUT contents.
module mpx_stereo_decoder_192 #(
  parameter int                     NBITS_PHASE      = 18,
  parameter int                     NBITS_PHASE_FRAC = 12,
  parameter int                     NSAMPLES_LUT     = 64,
  parameter logic [NBITS_PHASE-1:0] PHASEINC_38      = 18'b001100_101010101010,
  parameter int                     DECIM            = 4
`ifdef PILOT_DETECT_EN
  , parameter logic [19:0]          PILOT_THRESH     = 20'd16
`endif
) (
  input  logic                   clock,
  input  logic                   reset,
  mpx_stereo_decoder_192_if.slave bus
);

  localparam int IDX_W      = $clog2(NSAMPLES_LUT);
  localparam int LOG2_DECIM = $clog2(DECIM);
  localparam int CNT_W      = LOG2_DECIM + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_MULT, S_ACC, S_COMBINE, S_OUT
`ifdef PILOT_DETECT_EN
    , S_MULT2, S_PACC
`endif
  } state_t;

  state_t state, state_nxt;

  logic [NBITS_PHASE-1:0] phase38;
  logic [IDX_W-1:0]       idx38;
  logic signed [19:0]     mpx_r;
  logic signed [7:0]      sine38_r;
  logic signed [7:0]      mult_b;
  logic [2:0]             it;
  logic signed [27:0]     prod;
  logic signed [27:0]     mpx_ext;
  logic signed [27:0]     pp;
  logic signed [27:0]     term;
  logic signed [21:0]     sum_m;
  logic signed [21:0]     m_val;
  logic signed [23:0]     sum_s;
  logic signed [23:0]     s_val;
  logic signed [24:0]     l_full;
  logic signed [24:0]     r_full;
  logic [CNT_W-1:0]       dcnt;
  logic signed [17:0]     lo_left;
  logic signed [17:0]     lo_right;
  logic                   overrun_r;
  logic                   accept;
  logic                   ready;

`ifdef PILOT_DETECT_EN
  localparam logic [NBITS_PHASE-1:0] PHASEINC_19 = 18'b000110_010101010101;
  logic [NBITS_PHASE-1:0] phase19;
  logic [IDX_W-1:0]       idx19;
  logic signed [7:0]      sine19_r;
  logic signed [31:0]     corr;
  logic signed [31:0]     corr_nxt;
  logic [31:0]            corr_abs;
  logic [7:0]             pcnt;
  logic                   pilot_r;
`endif

  // First quadrant of round(127*sin(2*pi*k/64)), k = 0..16
  function automatic logic [6:0] quarter_sine(input logic [4:0] k);
    case (k)
      5'd0:    quarter_sine = 7'd0;
      5'd1:    quarter_sine = 7'd12;
      5'd2:    quarter_sine = 7'd25;
      5'd3:    quarter_sine = 7'd37;
      5'd4:    quarter_sine = 7'd49;
      5'd5:    quarter_sine = 7'd60;
      5'd6:    quarter_sine = 7'd71;
      5'd7:    quarter_sine = 7'd81;
      5'd8:    quarter_sine = 7'd90;
      5'd9:    quarter_sine = 7'd98;
      5'd10:   quarter_sine = 7'd106;
      5'd11:   quarter_sine = 7'd112;
      5'd12:   quarter_sine = 7'd117;
      5'd13:   quarter_sine = 7'd122;
      5'd14:   quarter_sine = 7'd125;
      5'd15:   quarter_sine = 7'd126;
      5'd16:   quarter_sine = 7'd127;
      default: quarter_sine = 7'd0;
    endcase
  endfunction

  // Full 64-entry sine: quadrants 1 and 3 mirror the index, quadrants 2 and 3 negate.
  function automatic logic signed [7:0] sine_lut(input logic [IDX_W-1:0] idx);
    logic [4:0]        k;
    logic signed [7:0] mag;
    k   = idx[4] ? (5'd16 - {1'b0, idx[3:0]}) : {1'b0, idx[3:0]};
    mag = $signed({1'b0, quarter_sine(k)});
    return idx[5] ? -mag : mag;
  endfunction

  function automatic logic signed [17:0] sat18(input logic signed [24:0] x);
    if (x > 25'sd131071)
      return 18'sh1FFFF;
    else if (x < -25'sd131072)
      return 18'sh20000;
    else
      return x[17:0];
  endfunction

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_OUT: state_nxt = bus.clken_192 ? S_MULT : S_IDLE;
      S_MULT:        if (it == 3'd7) state_nxt = S_ACC;
`ifdef PILOT_DETECT_EN
      S_ACC:         state_nxt = S_MULT2;
      S_MULT2:       if (it == 3'd7) state_nxt = S_PACC;
      S_PACC:        state_nxt = (int'(dcnt) >= DECIM) ? S_COMBINE : S_IDLE;
`else
      S_ACC:         state_nxt = (int'(dcnt) + 1 >= DECIM) ? S_COMBINE : S_IDLE;
`endif
      S_COMBINE:     state_nxt = S_OUT;
      default:       state_nxt = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // OUT behaves like IDLE for acceptance so back-to-back blocks keep the minimum sample spacing.
  always_comb begin
    ready  = (state == S_OUT);
    accept = bus.clken_192 && ((state == S_IDLE) || (state == S_OUT));
  end

  // ---------------- datapath arithmetic ----------------
  always_comb begin
    idx38 = IDX_W'(phase38 >> NBITS_PHASE_FRAC);
`ifdef PILOT_DETECT_EN
    idx19  = IDX_W'(phase19 >> NBITS_PHASE_FRAC);
    mult_b = (state == S_MULT2) ? sine19_r : sine38_r;
`else
    mult_b = sine38_r;
`endif
    // Shift-add step; bit 7 of the sine has weight -128, so its partial product is subtracted.
    mpx_ext = 28'(mpx_r);
    pp      = mpx_ext <<< it;
    term    = '0;
    if (mult_b[it])
      term = (it == 3'd7) ? -pp : pp;

    m_val = sum_m >>> LOG2_DECIM;
    s_val = sum_s >>> LOG2_DECIM;
`ifdef PILOT_DETECT_EN
    if (!pilot_r)
      s_val = '0;
    corr_nxt = corr + 32'(prod >>> 6);
    corr_abs = corr_nxt[31] ? 32'(-corr_nxt) : 32'(corr_nxt);
`endif
    l_full = (25'(m_val) + 25'(s_val)) >>> 1;
    r_full = (25'(m_val) - 25'(s_val)) >>> 1;
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clock) begin
    if (reset) begin
      phase38   <= '0;
      mpx_r     <= '0;
      sine38_r  <= '0;
      it        <= '0;
      prod      <= '0;
      sum_m     <= '0;
      sum_s     <= '0;
      dcnt      <= '0;
      lo_left   <= '0;
      lo_right  <= '0;
      overrun_r <= 1'b0;
`ifdef PILOT_DETECT_EN
      phase19   <= '0;
      sine19_r  <= '0;
      corr      <= '0;
      pcnt      <= '0;
      pilot_r   <= 1'b0;
`endif
    end else begin
      // The oscillators track every input sample, accepted or not, to stay phase-coherent.
      if (bus.clken_192) begin
        phase38 <= phase38 + PHASEINC_38;
`ifdef PILOT_DETECT_EN
        phase19 <= phase19 + PHASEINC_19;
`endif
      end
      if (bus.clken_192 && !accept)
        overrun_r <= 1'b1;

      case (state)
        S_IDLE, S_OUT: begin
          if (accept) begin
            mpx_r    <= bus.MPX_IN;
            sine38_r <= sine_lut(idx38);
`ifdef PILOT_DETECT_EN
            sine19_r <= sine_lut(idx19);
`endif
            it       <= '0;
            prod     <= '0;
          end
        end
`ifdef PILOT_DETECT_EN
        S_MULT, S_MULT2: begin
`else
        S_MULT: begin
`endif
          prod <= prod + term;
          it   <= it + 3'd1;
        end
        S_ACC: begin
          sum_m <= sum_m + 22'(mpx_r);
          sum_s <= sum_s + 24'(prod >>> 6);
          dcnt  <= dcnt + 1'b1;
`ifdef PILOT_DETECT_EN
          prod  <= '0;
`endif
        end
`ifdef PILOT_DETECT_EN
        S_PACC: begin
          if (pcnt == 8'd191) begin
            pcnt    <= '0;
            corr    <= '0;
            pilot_r <= ((corr_abs >> 8) >= 32'(PILOT_THRESH));
          end else begin
            pcnt <= pcnt + 8'd1;
            corr <= corr_nxt;
          end
        end
`endif
        S_COMBINE: begin
          lo_left  <= sat18(l_full);
          lo_right <= sat18(r_full);
          sum_m    <= '0;
          sum_s    <= '0;
          dcnt     <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.LO_LEFT        = lo_left;
  assign bus.LO_RIGHT       = lo_right;
  assign bus.ready_block_48 = ready;
  assign bus.overrun        = overrun_r;
`ifdef PILOT_DETECT_EN
  assign bus.pilot_locked   = pilot_r;
`else
  assign bus.pilot_locked   = 1'b0;
`endif

endmodule
